demux_regbank16: RTL and testbench
==================================

DEMUX_REGBANK16 -- requirements
Module: demux_regbank16

Interface
REQ-001 SHALL have port CLK  input  1  rising-edge clock.
REQ-002 SHALL have port RSTN  input  1  reset, asynchronous, active-low; clock CLK.
REQ-003 SHALL have port d  input  16  write data.
REQ-004 SHALL have port sel  input  3  destination register index, 0..7.
REQ-005 SHALL have port load  input  1  write request, sampled each rising CLK edge.
REQ-006 SHALL have port clr  input  1  synchronous clear of all registers and pending write.
REQ-007 SHALL have ports q0..q7  output  16 each  current contents of registers 0..7.
REQ-008 SHALL have port wvalid  output  1  one-cycle pulse when a write commits.
REQ-009 SHALL have port widx  output  3  index of the most recently committed write.
REQ-010 SHALL have port written  output  8  sticky per-register written flags.
REQ-011 SHALL have port wcount  output  8  committed-write counter.

Function
REQ-012 SHALL capture d, sel and load into a stage-1 request register (req_d, req_sel, req_v) on each rising edge.
REQ-013 SHALL commit a valid stage-1 request into register req_sel on the next rising edge; load at edge N makes the new value visible on q<sel> after edge N+1 (2-cycle latency).
REQ-014 SHALL leave all non-selected registers unchanged on a commit; exactly one register is written per commit.
REQ-015 SHALL accept back-to-back load every cycle with no stall and commit every request in order.
REQ-016 SHALL, for back-to-back writes to the same index, leave the later data in the register.
REQ-017 SHALL assert wvalid for exactly the cycle following a commit edge; widx SHALL update to the committed index on that edge and otherwise hold.
REQ-018 SHALL set written[req_sel] on commit; bits SHALL only clear on clr or reset.
REQ-019 SHALL increment wcount by 1 per commit, modulo 256 (255 wraps to 0).
REQ-020 SHALL, on a rising edge with clr=1, zero q0..q7, written, wcount and widx, deassert wvalid, and discard both the stage-1 request and any load sampled on that edge.
REQ-021 SHALL give clr priority over a simultaneous commit and a simultaneous load.
REQ-022 SHALL ignore sel when load=0; a stage-1 entry with req_v=0 SHALL commit nothing.

Reset
REQ-023 SHALL, while RSTN=0, force q0..q7=0, written=0, wcount=0, widx=0, wvalid=0, req_v=0, independent of CLK.
REQ-024 SHALL squash any in-flight stage-1 request when RSTN asserts mid-operation; no commit occurs after RSTN deasserts unless a new load is sampled.
REQ-025 SHALL sample load normally on the first rising edge after RSTN deasserts.

Structure
REQ-026 SHALL place constants NREG=8, DW=16, IW=3 and the write-request record type (data, index, valid) in shared package cpu_regs_pkg.
REQ-027 SHALL implement the 3-to-8 one-hot write-enable decode as sub-module wdec3to8 (input idx, en; output onehot[7:0]).
REQ-028 SHALL keep q0..q7 as direct register outputs with no combinational path from d, sel or load.

Verification
REQ-029 SHALL cover: reset release, load=1 sel=5 d=16'hA5A5 at edge 1 -> q5=A5A5 after edge 2, wvalid high one cycle, widx=5, written=8'h20, wcount=1, other q=0.
REQ-030 SHALL cover: 8 consecutive loads sel=0..7 d=16'h1000+i -> each qi=1000+i two edges after its load, wcount=8, written=8'hFF, wvalid high 8 consecutive cycles.
REQ-031 SHALL cover: loads sel=3 d=16'h0001 then sel=3 d=16'h0002 back-to-back -> q3 ends 16'h0002, wcount=2.
REQ-032 SHALL cover: load sel=2 d=16'hBEEF, clr=1 on the next edge -> q2 stays 0, wvalid never asserts, wcount=0, written=0.
REQ-033 SHALL cover: 256 commits from reset -> wcount=0 after wrap; 257th commit -> wcount=1.
REQ-034 SHALL cover: RSTN pulsed low between load edge and commit edge -> all outputs 0 immediately, no commit after release.

Source files
------------

// File: rtl/cpu_regs_pkg.sv
// Shared sizing and the write-request record for the register bank.
// No logic; latency and backpressure are properties of the modules that import it.
package cpu_regs_pkg;

   localparam int NREG = 8;
   localparam int DW   = 16;
   localparam int IW   = 3;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [IW-1:0] idx;
      logic          valid;
   } wreq_t;

endpackage

// File: rtl/wdec3to8.sv
// 3-to-8 one-hot write-enable decode; all zeros when en is low.
// Combinational, zero latency; no backpressure.
module wdec3to8
   import cpu_regs_pkg::*;
(
   input  logic [IW-1:0]   idx,
   input  logic            en,
   output logic [NREG-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) begin
         onehot[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/demux_regbank16.sv
// Eight 16-bit registers written through a one-entry request stage; q is valid two edges after load.
// Latency 2 cycles load-to-q; accepts a write every cycle, never stalls, no backpressure.
module demux_regbank16
   import cpu_regs_pkg::*;
(
   input  logic            CLK,
   input  logic            RSTN,
   input  logic [DW-1:0]   d,
   input  logic [IW-1:0]   sel,
   input  logic            load,
   input  logic            clr,
   output logic [DW-1:0]   q0,
   output logic [DW-1:0]   q1,
   output logic [DW-1:0]   q2,
   output logic [DW-1:0]   q3,
   output logic [DW-1:0]   q4,
   output logic [DW-1:0]   q5,
   output logic [DW-1:0]   q6,
   output logic [DW-1:0]   q7,
   output logic            wvalid,
   output logic [IW-1:0]   widx,
   output logic [NREG-1:0] written,
   output logic [7:0]      wcount
);

   wreq_t           req;
   logic [NREG-1:0] we;
   logic [DW-1:0]   regs [NREG];

   wdec3to8 u_wdec (
      .idx    (req.idx),
      .en     (req.valid),
      .onehot (we)
   );

   // Stage 1: clr drops both the held request and whatever load arrives with it.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         req <= '0;
      end else if (clr) begin
         req <= '0;
      end else begin
         req.data  <= d;
         req.idx   <= sel;
         req.valid <= load;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (clr) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (we[i]) regs[i] <= req.data;
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         wvalid  <= 1'b0;
         widx    <= '0;
         written <= '0;
         wcount  <= '0;
      end else if (clr) begin
         wvalid  <= 1'b0;
         widx    <= '0;
         written <= '0;
         wcount  <= '0;
      end else begin
         wvalid <= req.valid;
         if (req.valid) begin
            widx    <= req.idx;
            written <= written | we;
            wcount  <= wcount + 8'd1;
         end
      end
   end

   assign q0 = regs[0];
   assign q1 = regs[1];
   assign q2 = regs[2];
   assign q3 = regs[3];
   assign q4 = regs[4];
   assign q5 = regs[5];
   assign q6 = regs[6];
   assign q7 = regs[7];

endmodule

// File: tb/tb_demux_regbank16.sv
// Scoreboard bench for demux_regbank16: stimulus pushes expected commits, a negedge monitor pops and checks.
// Between commits the monitor also checks that all state holds.
module tb_demux_regbank16;
   import cpu_regs_pkg::*;

   logic            CLK = 1'b0;
   logic            RSTN = 1'b0;
   logic [DW-1:0]   d = '0;
   logic [IW-1:0]   sel = '0;
   logic            load = 1'b0;
   logic            clr = 1'b0;
   logic [DW-1:0]   q0, q1, q2, q3, q4, q5, q6, q7;
   logic            wvalid;
   logic [IW-1:0]   widx;
   logic [NREG-1:0] written;
   logic [7:0]      wcount;

   logic [NREG-1:0][DW-1:0] qv;
   assign qv = {q7, q6, q5, q4, q3, q2, q1, q0};

   demux_regbank16 dut (
      .CLK(CLK), .RSTN(RSTN), .d(d), .sel(sel), .load(load), .clr(clr),
      .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .q6(q6), .q7(q7),
      .wvalid(wvalid), .widx(widx), .written(written), .wcount(wcount)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [IW-1:0]           idx;
      logic [NREG-1:0][DW-1:0] q;
      logic [NREG-1:0]         wr;
      logic [7:0]              cnt;
      int                      edge_n;
   } exp_t;

   int   vectors = 0;
   int   miscompares = 0;
   int   edge_no = 0;
   exp_t sbq[$];
   exp_t hold;
   exp_t m;
   bit   pend_v = 0;

   always @(posedge CLK) edge_no <= edge_no + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   task automatic model_zero();
      m.idx = '0; m.q = '0; m.wr = '0; m.cnt = '0; m.edge_n = 0;
      hold = m;
   endtask

   // Monitor: a wvalid pulse must match the oldest expected commit, otherwise state must hold.
   always @(negedge CLK) begin
      if (RSTN) begin
         if (wvalid) begin
            if (sbq.size() == 0) begin
               chk("unexpected_wvalid", {127'd0, wvalid}, 128'd0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("commit_edge", 128'(edge_no), 128'(e.edge_n));
               chk("widx", {125'd0, widx}, {125'd0, e.idx});
               chk("q_all", qv, e.q);
               chk("written", {120'd0, written}, {120'd0, e.wr});
               chk("wcount", {120'd0, wcount}, {120'd0, e.cnt});
               hold = e;
            end
         end else begin
            chk("hold_q", qv, hold.q);
            chk("hold_ctl", {109'd0, widx, written, wcount}, {109'd0, hold.idx, hold.wr, hold.cnt});
         end
      end
   end

   task automatic cyc(input bit ld, input logic [IW-1:0] s, input logic [DW-1:0] dd, input bit c);
      exp_t e;
      load = ld; sel = s; d = dd; clr = c;
      @(posedge CLK);
      #1;
      if (c) begin
         if (pend_v) void'(sbq.pop_back());
         pend_v = 0;
         model_zero();
      end else begin
         pend_v = ld;
         if (ld) begin
            m.q[s]  = dd;
            m.wr[s] = 1'b1;
            m.cnt   = m.cnt + 8'd1;
            m.idx   = s;
            e = m;
            e.edge_n = edge_no + 1;
            sbq.push_back(e);
         end
      end
      load = 1'b0; clr = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 3'd7, 16'hFFFF, 1'b0);
   endtask

   // Called just after an edge; asserts reset mid-cycle and releases away from the next edge.
   task automatic reset_pulse();
      #1 RSTN = 1'b0;
      #1;
      chk("rst_q_zero", qv, 128'd0);
      chk("rst_ctl_zero", {113'd0, wvalid, widx, written, wcount}, 128'd0);
      if (pend_v) void'(sbq.pop_back());
      pend_v = 0;
      model_zero();
      @(negedge CLK);
      #2 RSTN = 1'b1;
   endtask

   initial begin
      model_zero();
      #3;
      chk("init_q_zero", qv, 128'd0);
      chk("init_ctl_zero", {113'd0, wvalid, widx, written, wcount}, 128'd0);
      #9 RSTN = 1'b1;

      cyc(1'b1, 3'd5, 16'hA5A5, 1'b0);
      idle(3);

      for (int i = 0; i < 8; i++) cyc(1'b1, 3'(i), 16'h1000 + 16'(i), 1'b0);
      idle(3);

      cyc(1'b1, 3'd3, 16'h0001, 1'b0);
      cyc(1'b1, 3'd3, 16'h0002, 1'b0);
      idle(3);
      chk("q3_last_wins", {112'd0, q3}, 128'h2);

      // clr the edge after a load, then clr together with a new load.
      cyc(1'b1, 3'd2, 16'hBEEF, 1'b0);
      cyc(1'b0, 3'd0, 16'h0000, 1'b1);
      idle(2);
      cyc(1'b1, 3'd4, 16'h1234, 1'b0);
      cyc(1'b1, 3'd6, 16'h5555, 1'b1);
      idle(3);
      chk("clr_q2_zero", {112'd0, q2}, 128'd0);

      cyc(1'b1, 3'd1, 16'h7777, 1'b0);
      reset_pulse();
      idle(3);
      cyc(1'b1, 3'd0, 16'h4242, 1'b0);
      idle(3);

      reset_pulse();
      for (int i = 0; i < 256; i++) cyc(1'b1, 3'(i), 16'(i) ^ 16'h3C00, 1'b0);
      idle(3);
      chk("wcount_wrap", {120'd0, wcount}, 128'd0);
      cyc(1'b1, 3'd6, 16'hCAFE, 1'b0);
      idle(3);
      chk("wcount_after_wrap", {120'd0, wcount}, 128'd1);

      chk("scoreboard_empty", 128'(sbq.size()), 128'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
